// File: rtl/bindct_pkg.sv
// Shared types and constants for the binDCT datapath (row stage,
// transpose buffer and column stage).
`timescale 1ns/1ps
package bindct_pkg;

  localparam int N      = 8;
  localparam int DATA_W = 11;
  localparam int IDX_W  = 3;

  typedef logic signed [DATA_W-1:0] coef_t;
  typedef coef_t [0:N-1]            vec_t;
  typedef logic [IDX_W-1:0]         idx_t;

  // One row write into a transpose bank.
  typedef struct packed {
    logic we;
    idx_t row;
    vec_t data;
  } tp_wr_req_t;

  // True on the final row/column of an 8x8 block.
  function automatic logic is_last(input idx_t i);
    return i == idx_t'(N - 1);
  endfunction

endpackage

// File: rtl/bindct_tp_bank.sv
// One 8x8 coefficient bank: written a row at a time, read a column at a time.
`timescale 1ns/1ps
module bindct_tp_bank
  import bindct_pkg::*;
(
  input  logic       clk,
  input  logic       srstn,
  input  tp_wr_req_t wr,
  input  idx_t       rd_col,
  output vec_t       rd_vec
);

  vec_t mem [0:N-1];

  genvar r;
  generate
    for (r = 0; r < N; r++) begin : g_row
      // Row storage; cleared on reset so stale data never leaks after a restart.
      always_ff @(posedge clk or negedge srstn) begin
        if (!srstn)
          mem[r] <= '0;
        else if (wr.we && (wr.row == idx_t'(r)))
          mem[r] <= wr.data;
      end

      // Column read: element r of the output is row r at the selected column.
      assign rd_vec[r] = mem[r][rd_col];
    end
  endgenerate

endmodule

// File: rtl/bindct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the binDCT row and column passes.
// Rows go into one bank while the other bank drains column by column.
`timescale 1ns/1ps
module bindct_transpose_buf
  import bindct_pkg::*;
#(
  parameter int DATA_W = 11,
  parameter int N      = 8
) (
  input  logic                     clk,
  input  logic                     srstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_row [0:N-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_col [0:N-1],
  output logic [2:0]               out_idx,
  output logic                     out_last
);

  logic [1:0] full, full_nxt;
  logic       wr_bank, rd_bank;
  idx_t       wr_row, rd_col;
  logic       wr_fire, rd_fire;

  vec_t       in_vec, sel_vec;
  tp_wr_req_t wr_req   [2];
  vec_t       bank_col [2];

  // Handshakes depend only on registered flags, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  assign sel_vec   = rd_bank ? bank_col[1] : bank_col[0];
  assign out_idx   = rd_col;
  assign out_last  = out_valid && is_last(rd_col);

  genvar c, b;
  generate
    for (c = 0; c < N; c++) begin : g_lane
      assign in_vec[c]  = in_row[c];
      assign out_col[c] = sel_vec[c];
    end

    for (b = 0; b < 2; b++) begin : g_bank
      assign wr_req[b] = '{we:   wr_fire && (wr_bank == 1'(b)),
                           row:  wr_row,
                           data: in_vec};

      bindct_tp_bank u_bank (
        .clk    (clk),
        .srstn  (srstn),
        .wr     (wr_req[b]),
        .rd_col (rd_col),
        .rd_vec (bank_col[b])
      );
    end
  endgenerate

  // Full flags: the write side sets its bank after row 7, the read side clears
  // its bank after column 7. They always target different banks, so both
  // updates can land in the same cycle.
  always_comb begin
    full_nxt = full;
    if (wr_fire && is_last(wr_row))
      full_nxt[wr_bank] = 1'b1;
    if (rd_fire && is_last(rd_col))
      full_nxt[rd_bank] = 1'b0;
  end

  // Flag register.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn)
      full <= 2'b00;
    else
      full <= full_nxt;
  end

  // Write pointer: row counter wraps to 0 and flips banks at the end of a block.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      wr_row  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_row <= wr_row + 1'b1;
      if (is_last(wr_row))
        wr_bank <= ~wr_bank;
    end
  end

  // Read pointer: column counter holds under backpressure, flips banks after column 7.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      rd_col  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      rd_col <= rd_col + 1'b1;
      if (is_last(rd_col))
        rd_bank <= ~rd_bank;
    end
  end

endmodule

// File: tb/tb_bindct_transpose_buf.sv
`timescale 1ns/1ps
module tb_bindct_transpose_buf;
  import bindct_pkg::*;

  logic       clk = 1'b0;
  logic       srstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  coef_t      in_row [0:N-1];
  logic       out_valid;
  logic       out_ready = 1'b0;
  coef_t      out_col [0:N-1];
  logic [2:0] out_idx;
  logic       out_last;

  int checks = 0;
  int errors = 0;

  typedef struct {
    coef_t      col [0:N-1];
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;

  bindct_transpose_buf dut (
    .clk       (clk),
    .srstn     (srstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pattern 0: 8*r+c offset by 100 per block. Pattern 1: alternating extremes.
  function automatic coef_t val(input int pat, input int blk, input int r, input int c);
    if (pat == 1)
      return ((r + c) % 2 == 1) ? coef_t'(1023) : coef_t'(-1024);
    return coef_t'(8 * r + c + 100 * blk);
  endfunction

  // Expected columns: column k element i is row i, coefficient k.
  task automatic push_block(input int pat, input int blk);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) e.col[i] = val(pat, blk, i, k);
      e.idx  = 3'(k);
      e.last = (k == N - 1);
      sb.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_row(input int pat, input int blk, input int r, output int stalls);
    logic rdy;
    in_valid = 1'b1;
    for (int c = 0; c < N; c++) in_row[c] = val(pat, blk, r, c);
    stalls = 0;
    forever begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      stalls++;
      if (stalls > 200) begin
        checks++; errors++;
        $display("FAIL send_row_timeout: got stalled %0d cycles expected accept", stalls);
        break;
      end
    end
  endtask

  task automatic send_block(input int pat, input int blk, output int stalls);
    int s;
    stalls = 0;
    push_block(pat, blk);
    for (int r = 0; r < N; r++) begin
      send_row(pat, blk, r, s);
      stalls += s;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", sb.size(), 0);
    chk("drain_out_valid", out_valid, 0);
  endtask

  // Monitor: compare every accepted column against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (srstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_col: got idx %0d expected no output", out_idx);
      end else begin
        e = sb.pop_front();
        for (int i = 0; i < N; i++)
          chk($sformatf("col%0d_elem%0d", e.idx, i), out_col[i], e.col[i]);
        chk("out_idx", out_idx, e.idx);
        chk("out_last", out_last, e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot;
    for (int c = 0; c < N; c++) in_row[c] = '0;

    // Reset held for three clocks
    #1;
    repeat (3) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      for (int i = 0; i < N; i++) chk("rst_out_col", out_col[i], 0);
      @(posedge clk); #1;
    end
    srstn = 1'b1;
    @(posedge clk); #1;

    // Single block
    out_ready = 1'b1;
    push_block(0, 0);
    for (int r = 0; r < N; r++) send_row(0, 0, r, st);
    in_valid = 1'b0;
    chk("single_valid_after_row7", out_valid, 1);
    chk("single_first_idx", out_idx, 0);
    wait_drain();

    // Streaming: four blocks back to back
    tot = 0;
    for (int b = 0; b < 4; b++) begin
      send_block(0, b, st);
      tot += st;
    end
    in_valid = 1'b0;
    chk("stream_stalls", tot, 0);
    wait_drain();

    // Backpressure: fill both banks, hold the 17th row off
    out_ready = 1'b0;
    send_block(0, 4, st);
    send_block(0, 5, st);
    chk("bp_in_ready_full", in_ready, 0);
    push_block(0, 6);
    in_valid = 1'b1;
    for (int c = 0; c < N; c++) in_row[c] = val(0, 6, 0, c);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_in_ready_held", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_idx", out_idx, 0);
      for (int i = 0; i < N; i++) chk("bp_stable_col0", out_col[i], val(0, 4, i, 0));
    end
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_in_ready_after_col%0d", k), in_ready, (k == N - 1) ? 1 : 0);
    end
    @(posedge clk); #1;
    for (int r = 1; r < N; r++) send_row(0, 6, r, st);
    in_valid = 1'b0;
    wait_drain();

    // Signed extremes
    send_block(1, 0, st);
    in_valid = 1'b0;
    wait_drain();

    // Mid-block reset while block 7 drains and block 8 is half written
    out_ready = 1'b0;
    send_block(0, 7, st);
    out_ready = 1'b1;
    push_block(0, 8);
    for (int r = 0; r < 5; r++) send_row(0, 8, r, st);
    srstn = 1'b0;
    in_valid = 1'b0;
    #1;
    sb.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_idx", out_idx, 0);
    for (int i = 0; i < N; i++) chk("midrst_out_col", out_col[i], 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    srstn = 1'b1;
    @(posedge clk); #1;
    send_block(0, 9, st);
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_idx", out_idx, 0);
    wait_drain();

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bindct_transpose_buf.md
Name: bindct_transpose_buf

Overview:
- Sits directly downstream of the 8-point forward binDCT row stage (fbindct).
- Captures eight consecutive 8-coefficient row vectors (one 8x8 block) and re-emits the block column by column, so the same binDCT core can perform the column pass of the 2-D transform.
- Double-buffered (ping-pong) so that one block is written while the previous block drains, sustaining one vector per cycle.

Parameters:
- DATA_W, 11, signed coefficient width; matches the fbindct output width (8-bit input plus 3 bits of growth).
- N, 8, transform size; rows per block and coefficients per vector. Fixed at 8; other values unsupported.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- srstn  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- in_valid  in  1  in_row holds a valid row vector.
- in_ready  out  1  buffer can accept a row this cycle.
- in_row  in  N x DATA_W signed (unpacked [0:N-1])  one row of fbindct coefficients.
- out_valid  out  1  out_col holds a valid column vector.
- out_ready  in  1  downstream accepts out_col this cycle.
- out_col  out  N x DATA_W signed (unpacked [0:N-1])  column vector; element i = row i of the block.
- out_idx  out  3  column index (0..7) of the current out_col.
- out_last  out  1  high with the column-7 beat of a block.

Behaviour:
- Storage: two banks (0 and 1), each 8x8 x DATA_W.
  - Per-bank flag full[b].
  - Write side: wr_bank, wr_row[2:0].
  - Read side: rd_bank, rd_col[2:0].
- Reset (async, srstn=0):
  - full=2'b00; wr_bank=rd_bank=0; wr_row=rd_col=0; all storage cleared to 0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_col all 0, out_idx=0, out_last=0.
- Write handshake:
  - in_ready = !full[wr_bank], combinational from registers only; no combinational path from out_ready.
  - On in_valid && in_ready: bank[wr_bank][wr_row][0..7] <= in_row; wr_row++.
  - If wr_row==7: full[wr_bank] <= 1, wr_bank toggles, wr_row <= 0.
- Read handshake:
  - out_valid = full[rd_bank]; out_col[i] = bank[rd_bank][i][rd_col]; out_idx = rd_col; out_last = out_valid && (rd_col==7).
  - All read outputs are combinational muxes of registered state.
  - On out_valid && out_ready: rd_col++. If rd_col==7: full[rd_bank] <= 0, rd_bank toggles, rd_col <= 0.
  - out_col must stay stable while out_valid=1 and out_ready=0.
- Latency: the first column is valid on the cycle after the handshake of row 7. Reads of a bank never overlap writes to it.
- Throughput: with in_valid=1 and out_ready=1 continuously, in_ready stays 1 and blocks stream back to back, 8 in / 8 out per 8 cycles.
- Simultaneous events:
  - The row-7 write of one bank and the column-7 read of the other bank in the same cycle update the two full bits independently; both take effect.
  - The same bank is never set and cleared in the same cycle (write requires !full, read requires full).
- Full condition: both banks full -> in_ready=0 until column 7 of rd_bank is accepted. in_ready rises on the next cycle.
- Empty condition: both banks empty -> out_valid=0. out_col shows the stale contents of rd_bank and is don't-care for checking.
- in_valid while in_ready=0: ignored, no state change. The upstream must hold in_row.
- Reset mid-block: partial rows and undrained blocks are discarded. The next accepted row is row 0 of bank 0.
- Data is passed unmodified: no rounding, saturation or width change.

Decomposition:
- Package bindct_pkg:
  - constants N=8 and DATA_W=11;
  - typedef coef_t = logic signed [DATA_W-1:0];
  - typedef vec_t = coef_t [0:N-1];
  - shared by fbindct, this block and the future column stage.
- Sub-module bindct_tp_bank: one 8x8 register bank with row write (we, row index, vec_t) and column read (col index -> vec_t), async clear on srstn. Instantiated twice.
- Handshake, pointers and full flags live in the top module.

Test Plan:
- Reset check: srstn=0 -> in_ready=1, out_valid=0, out_col all 0, out_idx=0. Hold values through 3 clocks; release.
- Single block: rows r=0..7 with in_row[c]=8*r+c, out_ready=1 -> out_valid rises 1 cycle after row 7; column k gives out_col[i]=8*i+k for k=0..7, out_last only on k=7, then out_valid=0.
- Streaming: 4 blocks back to back (block b adds 100*b), in_valid=out_ready=1 -> in_ready never drops; all 32 columns correct and in order.
- Backpressure: out_ready=0 while writing 16 rows -> in_ready=0 after row 15 and the 17th row is held off. Raise out_ready -> the first column of block 0 appears stable, and in_ready returns the cycle after block 0's column 7.
- Signed extremes: rows alternating -1024 and +1023 -> columns reproduce the exact values with no sign loss.
- Mid-block reset: assert srstn=0 after 5 rows of block 1 while block 0 is draining -> out_valid=0 at once. A fresh block afterwards emerges correct from bank 0.
